// File: rtl/spio_hss_multiplexer_link_supervisor_pkg.sv
// spio_hss_multiplexer_link_supervisor_pkg
//   Shared definitions for the HSS link supervisor and its backoff timer:
//   state encodings, state width and the number of consecutive aligned
//   cycles needed to confirm byte sync.
//   No ports (package).
package spio_hss_multiplexer_link_supervisor_pkg;

  localparam int STATE_BITS          = 3;
  localparam int SYNC_CONFIRM_CYCLES = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_RESET     = 3'd0,
    S_WAIT_SYNC = 3'd1,
    S_HANDSHAKE = 3'd2,
    S_UP        = 3'd3,
    S_BACKOFF   = 3'd4,
    S_MISMATCH  = 3'd5
  } sup_state_t;

endpackage

// File: rtl/spio_hss_multiplexer_link_supervisor_backoff_timer.sv
// spio_hss_multiplexer_backoff_timer
//   Loadable down-counter that times the backoff between link bring-up
//   attempts. The load value is BACKOFF_BASE << retry, clamped to all-ones
//   of TIMER_BITS. done is high once the count has one cycle left (or is
//   empty), so a load of N keeps the caller in its wait state for N cycles.
// Ports:
//   CLK_IN    in   clock
//   RESET_IN  in   synchronous active-low reset
//   load      in   load the backoff duration for the given retry count
//   retry     in   retry count used to scale the duration
//   done      out  wait complete (terminal count)
module spio_hss_multiplexer_backoff_timer #(
  parameter int BACKOFF_BASE = 256,
  parameter int TIMER_BITS   = 20,
  parameter int RETRY_BITS   = 3
) (
  input  logic                  CLK_IN,
  input  logic                  RESET_IN,
  input  logic                  load,
  input  logic [RETRY_BITS-1:0] retry,
  output logic                  done
);

  // Wide enough that the largest possible shift cannot lose bits before
  // the saturation check.
  localparam int WIDE_BITS = TIMER_BITS + (1 << RETRY_BITS);

  logic [WIDE_BITS-1:0]  base_wide;
  logic [WIDE_BITS-1:0]  shifted;
  logic [TIMER_BITS-1:0] load_val;
  logic [TIMER_BITS-1:0] count;

  assign base_wide = WIDE_BITS'(BACKOFF_BASE);
  assign shifted   = base_wide << retry;
  assign load_val  = (|shifted[WIDE_BITS-1:TIMER_BITS]) ? '1 : shifted[TIMER_BITS-1:0];

  always_ff @(posedge CLK_IN) begin
    if (!RESET_IN) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - TIMER_BITS'(1);
    end
  end

  assign done = (count <= TIMER_BITS'(1));

endmodule

// File: rtl/spio_hss_multiplexer_link_supervisor.sv
// spio_hss_multiplexer_link_supervisor
//   Brings up and recovers one HSS link: holds the transceiver and the
//   rx/tx control blocks in reset, waits for byte sync, supervises the
//   handshake with timeouts, declares the link up, and retries after an
//   exponential backoff on failure. Sole source of the transceiver rx reset
//   and the rx/tx control reset.
// Optional build macro: SPIO_HSS_SUPERVISOR_STATS_EN adds saturating
//   LINK_DROPS_OUT / TIMEOUTS_OUT event counters.
// Ports:
//   CLK_IN                 in   clock
//   RESET_IN               in   synchronous active-low reset
//   RXLOSSOFSYNC_IN[1:0]   in   transceiver byte-sync status, 0 = aligned
//   HANDSHAKE_COMPLETE_IN  in   handshake done (rx control)
//   VERSION_MISMATCH_IN    in   remote version incompatible (rx control)
//   GTP_RESET_OUT          out  transceiver rx reset, active-high
//   CTL_RESET_OUT          out  rx/tx control reset, active-high
//   LINK_UP_OUT            out  link usable by the frame layer
//   STATE_OUT[2:0]         out  current state encoding
//   RETRY_COUNT_OUT        out  consecutive failed attempts, saturating
//   LINK_DROPS_OUT[15:0]   out  exits from S_UP (stats build only)
//   TIMEOUTS_OUT[15:0]     out  sync/handshake timeouts (stats build only)
//
// state        | meaning
// S_RESET     | transceiver and control held in reset for GTP_RESET_CYCLES
// S_WAIT_SYNC | transceiver running, waiting for 4 aligned cycles
// S_HANDSHAKE | control released, waiting for handshake completion
// S_UP        | link usable; watching loss of sync and handshake status
// S_BACKOFF   | everything in reset for BACKOFF_BASE << retry cycles
// S_MISMATCH  | remote version incompatible; handshakes keep running
module spio_hss_multiplexer_link_supervisor
  import spio_hss_multiplexer_link_supervisor_pkg::*;
#(
  parameter int GTP_RESET_CYCLES  = 32,
  parameter int SYNC_TIMEOUT      = 65535,
  parameter int HANDSHAKE_TIMEOUT = 1000000,
  parameter int LOS_TOLERANCE     = 8,
  parameter int BACKOFF_BASE      = 256,
  parameter int TIMER_BITS        = 20,
  parameter int RETRY_BITS        = 3
) (
  input  logic                  CLK_IN,
  input  logic                  RESET_IN,
  input  logic [1:0]            RXLOSSOFSYNC_IN,
  input  logic                  HANDSHAKE_COMPLETE_IN,
  input  logic                  VERSION_MISMATCH_IN,
  output logic                  GTP_RESET_OUT,
  output logic                  CTL_RESET_OUT,
  output logic                  LINK_UP_OUT,
  output logic [STATE_BITS-1:0] STATE_OUT,
  output logic [RETRY_BITS-1:0] RETRY_COUNT_OUT
`ifdef SPIO_HSS_SUPERVISOR_STATS_EN
  ,
  output logic [15:0]           LINK_DROPS_OUT,
  output logic [15:0]           TIMEOUTS_OUT
`endif
);

  localparam int LOS_BITS  = $clog2(LOS_TOLERANCE + 1);
  localparam int SYNC_BITS = $clog2(SYNC_CONFIRM_CYCLES);

  localparam logic [TIMER_BITS-1:0] GTP_TC  = TIMER_BITS'(GTP_RESET_CYCLES - 1);
  localparam logic [TIMER_BITS-1:0] SYNC_TC = TIMER_BITS'(SYNC_TIMEOUT - 1);
  localparam logic [TIMER_BITS-1:0] HS_TC   = TIMER_BITS'(HANDSHAKE_TIMEOUT - 1);
  localparam logic [LOS_BITS-1:0]   LOS_TC  = LOS_BITS'(LOS_TOLERANCE - 1);
  localparam logic [SYNC_BITS-1:0]  SYNC_CONFIRM_TC = SYNC_BITS'(SYNC_CONFIRM_CYCLES - 1);

  sup_state_t            state_q, state_d;
  logic [TIMER_BITS-1:0] timer_q, timer_d;
  logic [SYNC_BITS-1:0]  sync_cnt_q, sync_cnt_d;
  logic [LOS_BITS-1:0]   los_run_q, los_run_d;
  logic [RETRY_BITS-1:0] retry_q, retry_d;
  logic                  aligned;
  logic                  enter_backoff;
  logic                  backoff_done;

  assign aligned = (RXLOSSOFSYNC_IN == 2'b00);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET: begin
        if (timer_q == GTP_TC) state_d = S_WAIT_SYNC;
      end
      S_WAIT_SYNC: begin
        if (aligned && sync_cnt_q == SYNC_CONFIRM_TC) state_d = S_HANDSHAKE;
        else if (timer_q == SYNC_TC)                   state_d = S_BACKOFF;
      end
      S_HANDSHAKE: begin
        if (VERSION_MISMATCH_IN)        state_d = S_MISMATCH;
        else if (HANDSHAKE_COMPLETE_IN) state_d = S_UP;
        else if (timer_q == HS_TC)      state_d = S_BACKOFF;
      end
      S_UP: begin
        // The run counter holds the count before this cycle, so TC-1 plus
        // one more bad cycle is the LOS_TOLERANCE-th consecutive one.
        if (!aligned && los_run_q == LOS_TC) state_d = S_BACKOFF;
        else if (!HANDSHAKE_COMPLETE_IN)     state_d = S_HANDSHAKE;
      end
      S_BACKOFF: begin
        if (backoff_done) state_d = S_RESET;
      end
      S_MISMATCH: begin
        if (!VERSION_MISMATCH_IN) state_d = S_HANDSHAKE;
      end
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    enter_backoff = (state_d == S_BACKOFF) && (state_q != S_BACKOFF);

    timer_d = timer_q;
    if (state_d != state_q)  timer_d = '0;
    else if (timer_q != '1)  timer_d = timer_q + TIMER_BITS'(1);

    sync_cnt_d = '0;
    if (state_q == S_WAIT_SYNC && state_d == S_WAIT_SYNC && aligned)
      sync_cnt_d = sync_cnt_q + SYNC_BITS'(1);

    los_run_d = '0;
    if (state_q == S_UP && state_d == S_UP && !aligned)
      los_run_d = los_run_q + LOS_BITS'(1);

    retry_d = retry_q;
    if (enter_backoff) begin
      if (retry_q != '1) retry_d = retry_q + RETRY_BITS'(1);
    end else if (state_q == S_HANDSHAKE && state_d == S_UP) begin
      retry_d = '0;
    end
  end

  // The backoff duration uses the already-incremented retry count.
  spio_hss_multiplexer_backoff_timer #(
    .BACKOFF_BASE (BACKOFF_BASE),
    .TIMER_BITS   (TIMER_BITS),
    .RETRY_BITS   (RETRY_BITS)
  ) u_backoff_timer (
    .CLK_IN   (CLK_IN),
    .RESET_IN (RESET_IN),
    .load     (enter_backoff),
    .retry    (retry_d),
    .done     (backoff_done)
  );

  // Outputs decode the next state so they change on the same edge as
  // STATE_OUT.
  always_ff @(posedge CLK_IN) begin
    if (!RESET_IN) begin
      state_q       <= S_RESET;
      timer_q       <= '0;
      sync_cnt_q    <= '0;
      los_run_q     <= '0;
      retry_q       <= '0;
      GTP_RESET_OUT <= 1'b1;
      CTL_RESET_OUT <= 1'b1;
      LINK_UP_OUT   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      sync_cnt_q    <= sync_cnt_d;
      los_run_q     <= los_run_d;
      retry_q       <= retry_d;
      GTP_RESET_OUT <= (state_d == S_RESET) || (state_d == S_BACKOFF);
      CTL_RESET_OUT <= (state_d == S_RESET) || (state_d == S_WAIT_SYNC) ||
                       (state_d == S_BACKOFF);
      LINK_UP_OUT   <= (state_d == S_UP);
    end
  end

  assign STATE_OUT       = state_q;
  assign RETRY_COUNT_OUT = retry_q;

`ifdef SPIO_HSS_SUPERVISOR_STATS_EN
  logic link_drop;
  logic timeout_hit;

  assign link_drop   = (state_q == S_UP) && (state_d != S_UP);
  assign timeout_hit = enter_backoff &&
                       ((state_q == S_WAIT_SYNC) || (state_q == S_HANDSHAKE));

  always_ff @(posedge CLK_IN) begin
    if (!RESET_IN) begin
      LINK_DROPS_OUT <= '0;
      TIMEOUTS_OUT   <= '0;
    end else begin
      if (link_drop && LINK_DROPS_OUT != 16'hFFFF)
        LINK_DROPS_OUT <= LINK_DROPS_OUT + 16'd1;
      if (timeout_hit && TIMEOUTS_OUT != 16'hFFFF)
        TIMEOUTS_OUT <= TIMEOUTS_OUT + 16'd1;
    end
  end
`endif

endmodule

// File: doc/spio_hss_multiplexer_link_supervisor.md
Name: spio_hss_multiplexer_link_supervisor

Overview:
Sequences bring-up and recovery of one HSS link around the rx/tx control pair.
- Holds the transceiver and the rx/tx control blocks in reset, then waits for byte sync.
- Lets the handshake run, supervises it with timeouts, and declares the link up.
- On failure, restarts the sequence after an exponential backoff.
- Sits between the transceiver wrapper and rx/tx control; the only source of their resets.

Parameters:
GTP_RESET_CYCLES, 32, cycles transceiver reset is held in S_RESET
SYNC_TIMEOUT, 65535, max cycles in S_WAIT_SYNC before backoff
HANDSHAKE_TIMEOUT, 1000000, max cycles in S_HANDSHAKE before backoff
LOS_TOLERANCE, 8, consecutive loss-of-sync cycles tolerated in S_UP
BACKOFF_BASE, 256, backoff cycles at retry count 0
TIMER_BITS, 20, width of shared timer; all cycle parameters must fit
RETRY_BITS, 3, width of retry counter; saturates at all-ones

Ports:
CLK_IN  in  1  clock
RESET_IN  in  1  reset; synchronous, active-low
RXLOSSOFSYNC_IN  in  2  transceiver byte-sync status; 2'b00 = aligned
HANDSHAKE_COMPLETE_IN  in  1  from rx control
VERSION_MISMATCH_IN  in  1  from rx control
GTP_RESET_OUT  out  1  transceiver rx reset, active-high
CTL_RESET_OUT  out  1  rx/tx control reset, active-high
LINK_UP_OUT  out  1  link usable by the frame layer
STATE_OUT  out  3  current state encoding
RETRY_COUNT_OUT  out  RETRY_BITS  consecutive failed attempts

Behaviour:
- All outputs are registered.
- Asserting RESET_IN (RESET_IN=0, sampled on CLK_IN) gives:
  - GTP_RESET_OUT=1, CTL_RESET_OUT=1, LINK_UP_OUT=0
  - STATE_OUT=S_RESET, RETRY_COUNT_OUT=0, timer=0, LOS run counter=0
- Reset mid-operation returns to these values on the next edge, from any state.
- State encodings: S_RESET=0, S_WAIT_SYNC=1, S_HANDSHAKE=2, S_UP=3, S_BACKOFF=4, S_MISMATCH=5.
- Timer:
  - Cleared on every state transition.
  - Otherwise increments and saturates at all-ones.
- S_RESET: GTP=1, CTL=1. At timer==GTP_RESET_CYCLES-1, go to S_WAIT_SYNC.
- S_WAIT_SYNC: GTP=0, CTL=1.
  - RXLOSSOFSYNC_IN==0 for 4 consecutive cycles: go to S_HANDSHAKE.
  - Else at timer==SYNC_TIMEOUT-1: go to S_BACKOFF.
- S_HANDSHAKE: GTP=0, CTL=0. Priority, highest first:
  1. VERSION_MISMATCH_IN=1: go to S_MISMATCH.
  2. HANDSHAKE_COMPLETE_IN=1: go to S_UP and clear retry count.
  3. timer==HANDSHAKE_TIMEOUT-1: go to S_BACKOFF.
  - Loss of sync is ignored here; rx control restarts the handshake itself.
- S_UP: LINK_UP_OUT=1 in the same cycle STATE_OUT==S_UP.
  - LOS run counter counts consecutive cycles with RXLOSSOFSYNC_IN!=0 and clears when it returns to 0.
  - Run counter reaches LOS_TOLERANCE: go to S_BACKOFF. This takes priority.
  - Else HANDSHAKE_COMPLETE_IN=0: go to S_HANDSHAKE (remote restarted the handshake); no backoff, no retry increment.
- S_BACKOFF: GTP=1, CTL=1, LINK_UP=0.
  - On entry, retry count increments, saturating.
  - Wait duration = BACKOFF_BASE << retry count at entry, saturated to all-ones of TIMER_BITS. Then go to S_RESET.
- S_MISMATCH: GTP=0, CTL=0, so handshakes keep flowing and the remote sees the version.
  - Leave to S_HANDSHAKE only when VERSION_MISMATCH_IN=0. The timer does not apply; no retries are counted.
- A transition out of S_UP deasserts LINK_UP_OUT on the same edge it is registered.

Optional Feature:
SPIO_HSS_SUPERVISOR_STATS_EN
- Defined: adds outputs LINK_DROPS_OUT[15:0] and TIMEOUTS_OUT[15:0].
  - LINK_DROPS_OUT increments on each exit from S_UP.
  - TIMEOUTS_OUT increments on each entry to S_BACKOFF from S_WAIT_SYNC or S_HANDSHAKE.
  - Both saturate at 16'hFFFF and are zeroed by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package/header (spio_hss_multiplexer_common.h): state encodings S_*, STATE_BITS=3, sync-confirm count 4.
- One sub-module, spio_hss_multiplexer_backoff_timer:
  - Loadable saturating down-counter.
  - Computes BACKOFF_BASE<<retry with saturation and flags done.
- Main FSM and LOS run counter stay in the top module.

Test Plan:
- Clean bring-up (GTP_RESET_CYCLES=32). Release reset, sync good from cycle 40, HANDSHAKE_COMPLETE_IN=1 at cycle 100:
  - GTP_RESET_OUT falls at cycle 32.
  - STATE_OUT=2 after 4 aligned cycles.
  - LINK_UP_OUT=1 one cycle after complete; RETRY_COUNT_OUT=0.
- Sync never arrives (SYNC_TIMEOUT=100, BACKOFF_BASE=16):
  - S_BACKOFF at 100 cycles, retry=1.
  - Backoffs last 32, 64, ... cycles.
  - Retry saturates at 7 and backoff stays at 16<<7.
- Handshake timeout (HANDSHAKE_TIMEOUT=500): complete never asserts -> S_BACKOFF after 500 cycles in S_HANDSHAKE, CTL_RESET_OUT=1.
- In S_UP:
  - RXLOSSOFSYNC_IN=2'b01 for 7 cycles -> stays up.
  - For 8 cycles -> S_BACKOFF, LINK_UP_OUT=0.
  - HANDSHAKE_COMPLETE_IN drop alone -> S_HANDSHAKE, retry unchanged.
- Mismatch: VERSION_MISMATCH_IN=1 in S_HANDSHAKE -> S_MISMATCH, held through 10^6 cycles. Drop it -> S_HANDSHAKE.
- RESET_IN=0 for one cycle while in S_UP with retry=3 -> next edge all outputs at reset values. With STATS_EN, counters read 0.
